// File: rtl/window_stream_if.sv
// Pixel-in / window-out handshake bundle for the sliding-window generator.
// master = pixel source and window sink, slave = window generator.
interface window_stream_if #(
  parameter int PIX      = 24,
  parameter int WIN_BITS = 216,
  parameter int ROW_W    = 5,
  parameter int COL_W    = 5
);
  logic                in_valid;
  logic                in_ready;
  logic                in_sof;
  logic [PIX-1:0]      in_data;
  logic                out_valid;
  logic                out_ready;
  logic [WIN_BITS-1:0] out_win;
  logic [ROW_W-1:0]    out_row;
  logic [COL_W-1:0]    out_col;
  logic                out_sof;
  logic                out_eol;
  logic                frame_done;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_win, out_row,
    input  out_col, out_sof, out_eol, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_win, out_row,
    output out_col, out_sof, out_eol, frame_done
  );
endinterface

// File: rtl/window_stream_gen.sv
// KxK sliding-window generator: line buffers plus window shift registers
// turn a raster pixel stream into one valid-region window per pixel.
module window_stream_gen #(
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_CH      = 3,
  parameter int CH_BITS     = 8
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          clear,
  window_stream_if.slave s
);
  localparam int PIX = NUM_CH * CH_BITS;
  localparam int K   = KERNEL_SIZE;
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
  localparam logic [RW-1:0] ROW_OUTL = RW'(IMG_HEIGHT - K);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_K    = CW'(K - 1);
  localparam logic [CW-1:0] COL_OUTL = CW'(IMG_WIDTH - K);

  logic [CW-1:0]  col, col_eff, col_nxt;
  logic [RW-1:0]  row, row_eff, row_nxt;
  logic           in_ready;
  logic           accept;
  logic           emit;
  logic           out_fire;
  logic           out_valid_q;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  logic           sof_q;
  logic           eol_q;
  logic           done_q;

  logic [PIX-1:0] lb      [K-1][IMG_WIDTH];
  logic [PIX-1:0] win     [K][K];
  logic [PIX-1:0] new_col [K];
  logic [K*K*PIX-1:0] win_flat;

  assign in_ready = !out_valid_q || s.out_ready;
  assign out_fire = out_valid_q && s.out_ready;

  // in_sof resynchronises the accepted pixel to (0,0)
  always_comb begin
    col_eff = s.in_sof ? '0 : col;
    row_eff = s.in_sof ? '0 : row;
    accept  = s.in_valid && in_ready && !clear;
    emit    = accept && (row_eff >= ROW_K) && (col_eff >= COL_K);
    col_nxt = col_eff + 1'b1;
    row_nxt = row_eff;
    if (col_eff == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
    end
  end

  // lb[0] holds the previous row, lb[K-2] the oldest
  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      new_col[j] = lb[K-2-j][col_eff];
    end
    new_col[K-1] = s.in_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][col_eff] <= s.in_data;
      for (int j = 1; j < K - 1; j++) begin
        lb[j][col_eff] <= lb[j-1][col_eff];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int wr = 0; wr < K; wr++) begin
        for (int wc = 0; wc < K; wc++) begin
          win[wr][wc] <= '0;
        end
      end
    end else if (accept) begin
      for (int wr = 0; wr < K; wr++) begin
        for (int wc = 0; wc < K - 1; wc++) begin
          win[wr][wc] <= win[wr][wc+1];
        end
        win[wr][K-1] <= new_col[wr];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int wr = 0; wr < K; wr++) begin
      for (int wc = 0; wc < K; wc++) begin
        win_flat[(wr*K+wc)*PIX +: PIX] = win[wr][wc];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= out_fire && (row_q == ROW_OUTL)
                && (col_q == COL_OUTL);
      if (clear) begin
        col         <= '0;
        row         <= '0;
        out_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          col <= col_nxt;
          row <= row_nxt;
        end
        if (emit) begin
          out_valid_q <= 1'b1;
          row_q       <= row_eff - ROW_K;
          col_q       <= col_eff - COL_K;
          sof_q       <= (row_eff == ROW_K)
                         && (col_eff == COL_K);
          eol_q       <= (col_eff == COL_LAST);
        end else if (s.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign s.in_ready   = in_ready;
  assign s.out_valid  = out_valid_q;
  assign s.out_win    = win_flat;
  assign s.out_row    = row_q;
  assign s.out_col    = col_q;
  assign s.out_sof    = sof_q;
  assign s.out_eol    = eol_q;
  assign s.frame_done = done_q;
endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen: 8x6 frames with K=3 RGB pixels
// {row,col,frame#}, plus a K=5 single-channel 10-bit build.
module tb_window_stream_gen;
  logic clk;
  logic rstb;
  logic clear;
  int   checks;
  int   errors;
  int   cyc;
  int   last_cyc;
  int   rdy_mode;

  `define CHK(tag, obs, exp) \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end

  window_stream_if #(.PIX(24), .WIN_BITS(216), .ROW_W(3), .COL_W(3)) b ();
  window_stream_if #(.PIX(10), .WIN_BITS(250), .ROW_W(3), .COL_W(3)) b5 ();

  window_stream_gen #(
    .IMG_WIDTH(8), .IMG_HEIGHT(6), .KERNEL_SIZE(3),
    .NUM_CH(3), .CH_BITS(8)
  ) dut (
    .clk(clk), .rstb(rstb), .clear(clear), .s(b)
  );

  window_stream_gen #(
    .IMG_WIDTH(8), .IMG_HEIGHT(6), .KERNEL_SIZE(5),
    .NUM_CH(1), .CH_BITS(10)
  ) dut5 (
    .clk(clk), .rstb(rstb), .clear(clear), .s(b5)
  );

  typedef struct {
    logic [215:0] win;
    logic [2:0]   row;
    logic [2:0]   col;
    logic         sof;
    logic         eol;
  } rec_t;

  typedef struct {
    logic [249:0] win;
    logic [2:0]   row;
    logic [2:0]   col;
  } rec5_t;

  rec_t  wq[$];
  rec5_t w5[$];
  int    fd_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    b.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       b.out_ready = 1'($urandom_range(0, 1));
        2:       b.out_ready = 1'b0;
        default: b.out_ready = 1'b1;
      endcase
    end
  end

  initial begin : mon
    rec_t  rr;
    rec5_t r5;
    forever begin
      @(negedge clk);
      cyc++;
      if (b.out_valid && b.out_ready) begin
        rr.win = b.out_win;
        rr.row = b.out_row;
        rr.col = b.out_col;
        rr.sof = b.out_sof;
        rr.eol = b.out_eol;
        wq.push_back(rr);
        if (b.out_row == 3'd3 && b.out_col == 3'd5) last_cyc = cyc;
      end
      if (b.frame_done) fd_q.push_back(cyc);
      if (b5.out_valid && b5.out_ready) begin
        r5.win = b5.out_win;
        r5.row = b5.out_row;
        r5.col = b5.out_col;
        w5.push_back(r5);
      end
    end
  end

  function automatic logic [215:0] ew(int r0, int c0, int f);
    logic [215:0] v;
    v = '0;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        v[(wr*3+wc)*24 +: 24] = {8'(r0+wr), 8'(c0+wc), 8'(f)};
    return v;
  endfunction

  task automatic push(input int r, input int c, input int f,
                      input bit sof, input bit gap);
    bit ok;
    int t;
    if (gap && $urandom_range(0, 2) == 0) begin
      b.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    b.in_valid = 1'b1;
    b.in_sof   = sof;
    b.in_data  = {8'(r), 8'(c), 8'(f)};
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = b.in_ready && !clear;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL push_timeout observed=%0d expected=%0d", t, 200);
    end
    b.in_valid = 1'b0;
    b.in_sof   = 1'b0;
  endtask

  task automatic frame(input int f, input bit gap, input bit sof0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        push(r, c, f, sof0 && r == 0 && c == 0, gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (b.out_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_seq(input int base, input int n, input int f0);
    int r0;
    int c0;
    for (int i = 0; i < n && base + i < wq.size(); i++) begin
      r0 = (i % 24) / 6;
      c0 = i % 6;
      `CHK("win_seq",
        {wq[base+i].row, wq[base+i].col, wq[base+i].sof,
         wq[base+i].eol, wq[base+i].win},
        {3'(r0), 3'(c0), 1'(r0 == 0 && c0 == 0), 1'(c0 == 5),
         ew(r0, c0, f0 + i / 24)})
    end
  endtask

  initial begin
    logic [215:0] snap;
    int t;
    checks = 0;
    errors = 0;
    cyc = 0;
    last_cyc = -10;
    rdy_mode = 0;
    rstb = 1'b0;
    clear = 1'b0;
    b.in_valid = 1'b0;
    b.in_sof = 1'b0;
    b.in_data = '0;
    b5.in_valid = 1'b0;
    b5.in_sof = 1'b0;
    b5.in_data = '0;
    b5.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_in_ready", b.in_ready, 1'b1)
    `CHK("rst_out_valid", b.out_valid, 1'b0)
    `CHK("rst_out_win", b.out_win, 216'd0)
    `CHK("rst_row_col", {b.out_row, b.out_col}, 6'd0)
    `CHK("rst_flags", {b.out_sof, b.out_eol, b.frame_done}, 3'b000)
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // 1: one frame, sink always ready
    frame(0, 1'b0, 1'b0);
    drain();
    `CHK("s1_count", wq.size(), 24)
    `CHK("s1_first_pos", {wq[0].row, wq[0].col, wq[0].sof}, 7'b000_000_1)
    `CHK("s1_tap0", wq[0].win[23:0], 24'h000000)
    `CHK("s1_tap8", wq[0].win[215:192], 24'h020200)
    `CHK("s1_last_pos", {wq[23].row, wq[23].col, wq[23].eol}, 7'b011_101_1)
    `CHK("s1_fd_count", fd_q.size(), 1)
    if (fd_q.size() > 0) begin
      `CHK("s1_fd_timing", fd_q[0], last_cyc + 1)
    end
    check_seq(0, 24, 0);

    // 2: sink stalls 5 cycles at the first window
    wq.delete();
    fd_q.delete();
    rdy_mode = 2;
    fork
      frame(0, 1'b0, 1'b0);
      begin
        t = 0;
        while (!b.out_valid && t < 300) begin
          @(negedge clk);
          t++;
        end
        `CHK("s2_reach", b.out_valid, 1'b1)
        snap = b.out_win;
        repeat (5) begin
          @(negedge clk);
          `CHK("s2_win_stable", b.out_win, snap)
          `CHK("s2_in_ready", b.in_ready, 1'b0)
        end
        rdy_mode = 0;
      end
    join
    drain();
    `CHK("s2_count", wq.size(), 24)
    check_seq(0, 24, 0);

    // 3: random gaps, two back-to-back frames
    wq.delete();
    fd_q.delete();
    rdy_mode = 1;
    frame(0, 1'b1, 1'b1);
    frame(1, 1'b1, 1'b0);
    rdy_mode = 0;
    drain();
    `CHK("s3_count", wq.size(), 48)
    `CHK("s3_fd_count", fd_q.size(), 2)
    check_seq(0, 48, 0);

    // 4: in_sof at pixel (3,4) abandons frame 0
    wq.delete();
    for (int p = 0; p < 28; p++) push(p / 8, p % 8, 0, 1'b0, 1'b0);
    push(0, 0, 1, 1'b1, 1'b0);
    for (int p = 1; p < 48; p++) begin
      if (p == 18) begin
        `CHK("s4_before_resync_win", wq.size(), 8)
      end
      push(p / 8, p % 8, 1, 1'b0, 1'b0);
      if (p == 18) begin
        `CHK("s4_resync_first",
          {b.out_valid, b.out_sof, b.out_row, b.out_col}, 8'b1_1_000_000)
      end
    end
    drain();
    `CHK("s4_count", wq.size(), 32)
    check_seq(0, 8, 0);
    check_seq(8, 24, 1);

    // 5a: clear mid-row 3, competing with a pixel
    for (int p = 0; p < 28; p++) push(p / 8, p % 8, 0, 1'b0, 1'b0);
    `CHK("s5_pre_clear_valid", b.out_valid, 1'b1)
    clear = 1'b1;
    b.in_valid = 1'b1;
    b.in_data = 24'hABCD09;
    @(posedge clk);
    #1;
    clear = 1'b0;
    b.in_valid = 1'b0;
    `CHK("s5_clear_valid", b.out_valid, 1'b0)
    wq.delete();
    fd_q.delete();
    frame(0, 1'b0, 1'b0);
    drain();
    `CHK("s5_clear_count", wq.size(), 24)
    `CHK("s5_clear_fd", fd_q.size(), 1)
    check_seq(0, 24, 0);

    // 5b: async reset mid-row 3
    for (int p = 0; p < 28; p++) push(p / 8, p % 8, 0, 1'b0, 1'b0);
    `CHK("s5_pre_rst_valid", b.out_valid, 1'b1)
    rstb = 1'b0;
    #1;
    `CHK("s5_rst_valid", b.out_valid, 1'b0)
    `CHK("s5_rst_ready", b.in_ready, 1'b1)
    @(posedge clk);
    #3;
    rstb = 1'b1;
    @(posedge clk);
    #1;
    wq.delete();
    frame(0, 1'b0, 1'b0);
    drain();
    `CHK("s5_rst_count", wq.size(), 24)
    check_seq(0, 24, 0);

    // 6: K=5 single-channel build, pixel = row*16 + col
    w5.delete();
    for (int p = 0; p < 48; p++) begin
      b5.in_valid = 1'b1;
      b5.in_data = 10'((p / 8) * 16 + (p % 8));
      @(posedge clk);
      #1;
    end
    b5.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    `CHK("s6_count", w5.size(), 8)
    if (w5.size() == 8) begin
      `CHK("s6_first_pos", {w5[0].row, w5[0].col}, 6'd0)
      `CHK("s6_first_tap24", w5[0].win[249:240], 10'd68)
      `CHK("s6_first_tap0", w5[0].win[9:0], 10'd0)
      `CHK("s6_mid_tap12", w5[3].win[129:120], 10'd37)
      `CHK("s6_last_pos", {w5[7].row, w5[7].col}, 6'b001_011)
      `CHK("s6_last_tap24", w5[7].win[249:240], 10'd87)
      `CHK("s6_last_tap0", w5[7].win[9:0], 10'd19)
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
